// File: rtl/multi_delta_counter.sv
// -----------------------------------------------------------------------------
// multi_delta_counter
//   NUM_CH independent up/down counters. Each channel is stepped by its own
//   delta and either wraps or saturates at the range limits. Each channel has
//   overflow/underflow flags (sticky or one-cycle pulse) and a registered
//   one-cycle compare-match pulse.
//
//   Per-channel priority on each edge: clear_i > load_i > en_i > hold.
//
// Ports (channel c uses bit [c] / slice [c*WIDTH +: WIDTH]):
//   clk_i       clock, all state updates on the rising edge
//   rst_i       asynchronous active-high reset
//   clear_i     synchronous clear of count, flags and match
//   load_i      load count from load_val_i
//   en_i        apply delta_i in the direction given by down_i
//   down_i      1 = count down, 0 = count up
//   sat_i       1 = saturate at the limits, 0 = wrap
//   delta_i     step size
//   load_val_i  load value
//   cmp_val_i   compare value, sampled together with the update
//   flag_clr_i  clear ovf/udf flags only (sticky mode only)
//   q_o         current counts, straight from registers
//   ovf_o       overflow flag
//   udf_o       underflow flag
//   match_o     one-cycle pulse after an update whose result equals cmp_val_i
// -----------------------------------------------------------------------------
module multi_delta_counter #(
  parameter int NUM_CH       = 4,
  parameter int WIDTH        = 8,
  parameter bit STICKY_FLAGS = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [NUM_CH-1:0]       clear_i,
  input  logic [NUM_CH-1:0]       load_i,
  input  logic [NUM_CH-1:0]       en_i,
  input  logic [NUM_CH-1:0]       down_i,
  input  logic [NUM_CH-1:0]       sat_i,
  input  logic [NUM_CH*WIDTH-1:0] delta_i,
  input  logic [NUM_CH*WIDTH-1:0] load_val_i,
  input  logic [NUM_CH*WIDTH-1:0] cmp_val_i,
  input  logic [NUM_CH-1:0]       flag_clr_i,
  output logic [NUM_CH*WIDTH-1:0] q_o,
  output logic [NUM_CH-1:0]       ovf_o,
  output logic [NUM_CH-1:0]       udf_o,
  output logic [NUM_CH-1:0]       match_o
);

  localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] CNT_ONES = {WIDTH{1'b1}};

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [WIDTH-1:0] cnt_r;
    logic             ovf_r;
    logic             udf_r;
    logic             match_r;

    logic [WIDTH-1:0] delta_s;
    logic [WIDTH-1:0] load_val_s;
    logic [WIDTH-1:0] cmp_val_s;
    logic [WIDTH:0]   sum_s;
    logic [WIDTH-1:0] cnt_nxt_s;
    logic             ovf_ev_s;
    logic             udf_ev_s;
    logic             match_nxt_s;
    logic             ovf_nxt_s;
    logic             udf_nxt_s;

    assign delta_s    = delta_i[c*WIDTH +: WIDTH];
    assign load_val_s = load_val_i[c*WIDTH +: WIDTH];
    assign cmp_val_s  = cmp_val_i[c*WIDTH +: WIDTH];

    // Count datapath: one extra bit holds the carry (up) or borrow (down).
    always_comb begin
      cnt_nxt_s   = cnt_r;
      ovf_ev_s    = 1'b0;
      udf_ev_s    = 1'b0;
      match_nxt_s = 1'b0;
      if (down_i[c]) begin
        sum_s = {1'b0, cnt_r} - {1'b0, delta_s};
      end else begin
        sum_s = {1'b0, cnt_r} + {1'b0, delta_s};
      end

      if (clear_i[c]) begin
        cnt_nxt_s = CNT_ZERO;
      end else if (load_i[c]) begin
        cnt_nxt_s   = load_val_s;
        match_nxt_s = (load_val_s == cmp_val_s);
      end else if (en_i[c]) begin
        if (sum_s[WIDTH]) begin
          // Range exceeded: the carry/borrow bit is the event, mode picks result.
          if (down_i[c]) begin
            udf_ev_s = 1'b1;
          end else begin
            ovf_ev_s = 1'b1;
          end
          if (sat_i[c]) begin
            cnt_nxt_s = down_i[c] ? CNT_ZERO : CNT_ONES;
          end else begin
            cnt_nxt_s = sum_s[WIDTH-1:0];
          end
        end else begin
          cnt_nxt_s = sum_s[WIDTH-1:0];
        end
        match_nxt_s = (cnt_nxt_s == cmp_val_s);
      end else begin
        cnt_nxt_s = cnt_r;
      end
    end

    // Flag next-state: in sticky mode a new event beats a coincident flag clear.
    always_comb begin
      ovf_nxt_s = 1'b0;
      udf_nxt_s = 1'b0;
      if (clear_i[c]) begin
        ovf_nxt_s = 1'b0;
        udf_nxt_s = 1'b0;
      end else if (STICKY_FLAGS) begin
        ovf_nxt_s = ovf_ev_s | (ovf_r & ~flag_clr_i[c]);
        udf_nxt_s = udf_ev_s | (udf_r & ~flag_clr_i[c]);
      end else begin
        ovf_nxt_s = ovf_ev_s;
        udf_nxt_s = udf_ev_s;
      end
    end

    // Channel state registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
        cnt_r   <= CNT_ZERO;
        ovf_r   <= 1'b0;
        udf_r   <= 1'b0;
        match_r <= 1'b0;
      end else begin
        cnt_r   <= cnt_nxt_s;
        ovf_r   <= ovf_nxt_s;
        udf_r   <= udf_nxt_s;
        match_r <= match_nxt_s;
      end
    end

    assign q_o[c*WIDTH +: WIDTH] = cnt_r;
    assign ovf_o[c]              = ovf_r;
    assign udf_o[c]              = udf_r;
    assign match_o[c]            = match_r;
  end

endmodule

// File: tb/tb_multi_delta_counter.sv
// -----------------------------------------------------------------------------
// tb_multi_delta_counter
//   Drives a sticky-flag instance and a pulse-flag instance with the same
//   stimulus (directed scenarios, then random cycles) and compares both with
//   an integer-arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_multi_delta_counter;

  localparam int NC   = 4;
  localparam int W    = 8;
  localparam int MAXV = 255;

  logic            clk;
  logic            rst;
  logic [NC-1:0]   clear, load, en, down, sat, flag_clr;
  logic [NC*W-1:0] delta, load_val, cmp_val;
  logic [NC*W-1:0] q_a, q_b;
  logic [NC-1:0]   ovf_a, udf_a, match_a, ovf_b, udf_b, match_b;

  int n_cmp;
  int n_bad;

  // reference model state
  int m_cnt   [NC];
  bit m_ovf_s [NC];
  bit m_udf_s [NC];
  bit m_ovf_p [NC];
  bit m_udf_p [NC];
  bit m_match [NC];

  multi_delta_counter #(.NUM_CH(NC), .WIDTH(W), .STICKY_FLAGS(1'b1)) u_sticky (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .load_i(load), .en_i(en),
    .down_i(down), .sat_i(sat), .delta_i(delta), .load_val_i(load_val),
    .cmp_val_i(cmp_val), .flag_clr_i(flag_clr), .q_o(q_a), .ovf_o(ovf_a),
    .udf_o(udf_a), .match_o(match_a)
  );

  multi_delta_counter #(.NUM_CH(NC), .WIDTH(W), .STICKY_FLAGS(1'b0)) u_pulse (
    .clk_i(clk), .rst_i(rst), .clear_i(clear), .load_i(load), .en_i(en),
    .down_i(down), .sat_i(sat), .delta_i(delta), .load_val_i(load_val),
    .cmp_val_i(cmp_val), .flag_clr_i(flag_clr), .q_o(q_b), .ovf_o(ovf_b),
    .udf_o(udf_b), .match_o(match_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cmp1(input string tag, input int c, input int obs, input int exp_v);
    n_cmp++;
    assert (obs === exp_v)
    else begin
      n_bad++;
      $error("FAIL %s ch%0d: observed %0d expected %0d", tag, c, obs, exp_v);
    end
  endtask

  task automatic check_all(input string tag);
    for (int c = 0; c < NC; c++) begin
      cmp1({tag, " q_sticky"}, c, int'(q_a[c*W +: W]), m_cnt[c]);
      cmp1({tag, " q_pulse"},  c, int'(q_b[c*W +: W]), m_cnt[c]);
      cmp1({tag, " ovf_sticky"}, c, int'(ovf_a[c]), int'(m_ovf_s[c]));
      cmp1({tag, " udf_sticky"}, c, int'(udf_a[c]), int'(m_udf_s[c]));
      cmp1({tag, " ovf_pulse"},  c, int'(ovf_b[c]), int'(m_ovf_p[c]));
      cmp1({tag, " udf_pulse"},  c, int'(udf_b[c]), int'(m_udf_p[c]));
      cmp1({tag, " match_sticky"}, c, int'(match_a[c]), int'(m_match[c]));
      cmp1({tag, " match_pulse"},  c, int'(match_b[c]), int'(m_match[c]));
    end
  endtask

  task automatic model_reset();
    for (int c = 0; c < NC; c++) begin
      m_cnt[c] = 0; m_ovf_s[c] = 0; m_udf_s[c] = 0;
      m_ovf_p[c] = 0; m_udf_p[c] = 0; m_match[c] = 0;
    end
  endtask

  task automatic idle_inputs();
    clear = '0; load = '0; en = '0; down = '0; sat = '0; flag_clr = '0;
    delta = '0; load_val = '0; cmp_val = '0;
  endtask

  task automatic set_ch(input int c, input int d, input int lv, input int cv);
    delta[c*W +: W]    = d[W-1:0];
    load_val[c*W +: W] = lv[W-1:0];
    cmp_val[c*W +: W]  = cv[W-1:0];
  endtask

  // Advance the model by one edge from the current inputs, then clock and check.
  task automatic tick(input string tag);
    for (int c = 0; c < NC; c++) begin
      int d, lv, cv, s;
      bit eo, eu;
      d  = int'(delta[c*W +: W]);
      lv = int'(load_val[c*W +: W]);
      cv = int'(cmp_val[c*W +: W]);
      eo = 1'b0;
      eu = 1'b0;
      if (clear[c]) begin
        m_cnt[c] = 0;
        m_match[c] = 0;
      end else if (load[c]) begin
        m_cnt[c] = lv;
        m_match[c] = (lv == cv);
      end else if (en[c]) begin
        if (!down[c]) begin
          s = m_cnt[c] + d;
          if (s > MAXV) begin
            eo = 1'b1;
            s = sat[c] ? MAXV : s - (MAXV + 1);
          end
        end else begin
          s = m_cnt[c] - d;
          if (s < 0) begin
            eu = 1'b1;
            s = sat[c] ? 0 : s + (MAXV + 1);
          end
        end
        m_cnt[c] = s;
        m_match[c] = (s == cv);
      end else begin
        m_match[c] = 0;
      end
      if (clear[c]) begin
        m_ovf_s[c] = 0;
        m_udf_s[c] = 0;
      end else begin
        m_ovf_s[c] = eo ? 1'b1 : (flag_clr[c] ? 1'b0 : m_ovf_s[c]);
        m_udf_s[c] = eu ? 1'b1 : (flag_clr[c] ? 1'b0 : m_udf_s[c]);
      end
      m_ovf_p[c] = eo;
      m_udf_p[c] = eu;
    end
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    model_reset();
    rst = 1'b1;
    #12;
    check_all("reset");
    rst = 1'b0;
    #1;
    check_all("after_release");

    // Count ch0 up to 5, then reset asynchronously between edges.
    en[0] = 1'b1;
    set_ch(0, 1, 0, 200);
    for (int i = 0; i < 5; i++) tick("count_up");
    cmp1("count_to_5", 0, int'(q_a[W-1:0]), 5);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_all("async_reset");
    #1;
    rst = 1'b0;
    tick("resume_after_reset");
    cmp1("resume_value", 0, int'(q_a[W-1:0]), 1);

    // Wrap up on ch0: 250 + 10 -> 4 with overflow; sticky flag holds.
    idle_inputs();
    load[0] = 1'b1;
    set_ch(0, 10, 250, 0);
    tick("wrap_load");
    load[0] = 1'b0;
    en[0] = 1'b1;
    tick("wrap_step");
    cmp1("wrap_q", 0, int'(q_a[W-1:0]), 4);
    en[0] = 1'b0;
    for (int i = 0; i < 3; i++) tick("wrap_idle");
    flag_clr[0] = 1'b1;
    tick("wrap_flag_clr");
    flag_clr[0] = 1'b0;

    // Saturate down on ch1: 3 - 5 -> 0 with underflow, re-fires, beats flag_clr.
    idle_inputs();
    sat[1] = 1'b1;
    down[1] = 1'b1;
    load[1] = 1'b1;
    set_ch(1, 5, 3, 99);
    tick("sat_load");
    load[1] = 1'b0;
    en[1] = 1'b1;
    tick("sat_step1");
    tick("sat_step2");
    flag_clr[1] = 1'b1;
    tick("sat_clr_vs_event");
    cmp1("sat_udf_held", 1, int'(udf_a[1]), 1);

    // delta = 0 with en: no event, match on unchanged value.
    idle_inputs();
    en[1] = 1'b1;
    sat[1] = 1'b1;
    set_ch(1, 0, 0, 0);
    tick("delta_zero");

    // Priority on ch2: clear beats load and en; load beats en.
    idle_inputs();
    clear[2] = 1'b1; load[2] = 1'b1; en[2] = 1'b1;
    set_ch(2, 9, 77, 0);
    tick("prio_clear");
    clear[2] = 1'b0;
    tick("prio_load");
    cmp1("prio_load_q", 2, int'(q_a[2*W +: W]), 77);

    // Match on ch3: 14 -> 17 -> 20 (pulse) -> hold (no pulse) -> 23.
    idle_inputs();
    load[3] = 1'b1;
    set_ch(3, 3, 14, 20);
    tick("match_load");
    load[3] = 1'b0;
    en[3] = 1'b1;
    tick("match_17");
    tick("match_20");
    cmp1("match_pulse_20", 3, int'(match_a[3]), 1);
    en[3] = 1'b0;
    tick("match_hold");
    en[3] = 1'b1;
    tick("match_23");

    // Independence: ch0 overflows while ch3 saturates downward.
    idle_inputs();
    load[0] = 1'b1; load[3] = 1'b1;
    set_ch(0, 100, 200, 1);
    set_ch(3, 50, 30, 1);
    tick("indep_load");
    load = '0;
    en[0] = 1'b1; en[3] = 1'b1; down[3] = 1'b1; sat[3] = 1'b1;
    tick("indep_event");
    en = '0;
    tick("indep_after");

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NC; c++) begin
        int d, nx;
        clear[c]    = ($urandom_range(0, 19) == 0);
        load[c]     = ($urandom_range(0, 7) == 0);
        en[c]       = ($urandom_range(0, 3) != 0);
        down[c]     = $urandom_range(0, 1);
        sat[c]      = $urandom_range(0, 1);
        flag_clr[c] = ($urandom_range(0, 5) == 0);
        d = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, MAXV));
        nx = down[c] ? (m_cnt[c] - d) & MAXV : (m_cnt[c] + d) & MAXV;
        set_ch(c, d, int'($urandom_range(0, MAXV)),
               $urandom_range(0, 1) ? nx : int'($urandom_range(0, MAXV)));
      end
      tick("random");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
